mw_add_seq: RTL



---
 rtl/mw_add_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/mw_add_seq.sv
// mw_add_seq: sequential multi-word adder front-end.
// Operand words arrive least-significant first over WORDS beats; each accepted
// beat does one W-bit add with the carry chained through a register, and the
// sum word is presented on a one-entry registered valid/ready output.
// Optional feature macro: MW_ADD_OVF_EN adds out_ovf (signed overflow of the
// full-width result, reported on the last word).
module mw_add_seq #(
    parameter int W     = 32,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_last,
    output logic         out_cout
`ifdef MW_ADD_OVF_EN
    ,
    output logic         out_ovf
`endif
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // One W-bit add with carry-in, result carried at W+1 bits
    function automatic logic [W:0] add_word(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic         cin);
        add_word = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic [W-1:0]  r_sum;
    logic          r_valid;
    logic          r_last;
    logic          r_cout;

    logic          w_accept;
    logic          w_cin;
    logic          w_last;
    logic [W:0]    w_full;

    // Single output register: a beat may enter whenever the slot is empty or
    // is being drained in this same cycle.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Beat 0 of every operation starts with carry-in 0 so a previous
    // operation's carry can never leak into the next one.
    assign w_cin  = (r_cnt == '0) ? 1'b0 : r_carry;
    assign w_last = (r_cnt == CW'(WORDS - 1));
    assign w_full = add_word(in_a, in_b, w_cin);

`ifdef MW_ADD_OVF_EN
    logic r_ovf;
    logic w_msb_cin;

    // Carry into the MSB recovered from the sum bit and the two operand bits
    assign w_msb_cin = w_full[W-1] ^ in_a[W-1] ^ in_b[W-1];
    assign out_ovf   = r_ovf;

    // Overflow flag register, loaded with the sum word and cleared by reset/abort
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_last & (w_msb_cin ^ w_full[W]);
        end
    end
`endif

    // Beat counter, carry chain and output register; abort drops any
    // beat offered in the same cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_sum   <= w_full[W-1:0];
            r_valid <= 1'b1;
            r_last  <= w_last;
            r_cout  <= w_last & w_full[W];
            r_carry <= w_full[W];
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign out_last  = r_last;
    assign out_cout  = r_cout;

endmodule
